rob_mw_core: RTL

ROB_MW_CORE -- requirements
Module: rob_mw_core

---
 rtl/rob_pkg.sv | 37 +++
 rtl/rob_mw_entry.sv | 53 +++++
 rtl/rob_mw_core.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared parameter bounds, pointer type and pointer arithmetic for the multi-way reorder buffer.
package rob_pkg;

    localparam int unsigned WAYS_MIN    = 1;
    localparam int unsigned WAYS_MAX    = 4;
    localparam int unsigned WBPORTS_MIN = 1;
    localparam int unsigned WBPORTS_MAX = 4;
    localparam int unsigned PTR_IDX_MAX = 16;

    // Ring pointer: index plus a wrap bit that flips each lap, so full and empty are distinguishable.
    typedef struct packed {
        logic                   wrap;
        logic [PTR_IDX_MAX-1:0] idx;
    } rob_ptr_t;

    // Linear value {wrap, idx[idxw-1:0]} of a pointer, counting modulo 2*DEPTH.
    function automatic int unsigned ptr_lin(input rob_ptr_t p, input int unsigned idxw);
        int unsigned lin;
        lin = 32'(p.idx) & ((32'd1 << idxw) - 32'd1);
        if (p.wrap) begin
            lin = lin | (32'd1 << idxw);
        end
        return lin;
    endfunction

    // Advance a pointer by n entries, wrapping the index and toggling the wrap bit on each lap.
    function automatic rob_ptr_t ptr_add(input rob_ptr_t p, input int unsigned n,
                                         input int unsigned idxw);
        rob_ptr_t    r;
        int unsigned lin;
        lin    = (ptr_lin(p, idxw) + n) & ((32'd2 << idxw) - 32'd1);
        r.wrap = ((lin >> idxw) & 32'd1) != 32'd0;
        r.idx  = PTR_IDX_MAX'(lin & ((32'd1 << idxw) - 32'd1));
        return r;
    endfunction

endpackage

// File: rtl/rob_mw_entry.sv
// One reorder-buffer entry: status flags (reset) and payload (not reset).
module rob_mw_entry
    import rob_pkg::*;
#(
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              flush_i,
    input  logic              alloc_i,
    input  logic              alloc_complete_i,
    input  logic [DWIDTH-1:0] alloc_data_i,
    input  logic              wb_hit_i,
    input  logic              wb_exc_i,
    input  logic              commit_i,
    output logic              valid_o,
    output logic              complete_o,
    output logic              exc_o,
    output logic [DWIDTH-1:0] data_o
);

    // Status flags: flush beats allocation, allocation beats commit and writeback.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            valid_o    <= 1'b0;
            complete_o <= 1'b0;
            exc_o      <= 1'b0;
        end else if (flush_i) begin
            valid_o    <= 1'b0;
            complete_o <= 1'b0;
            exc_o      <= 1'b0;
        end else if (alloc_i) begin
            valid_o    <= 1'b1;
            complete_o <= alloc_complete_i;
            exc_o      <= 1'b0;
        end else if (commit_i) begin
            valid_o    <= 1'b0;
            complete_o <= 1'b0;
            exc_o      <= 1'b0;
        end else if (valid_o && wb_hit_i) begin
            complete_o <= 1'b1;
            exc_o      <= exc_o | wb_exc_i;
        end
    end

    // Payload captured on allocation only.
    always_ff @(posedge clk_i) begin
        if (alloc_i && !flush_i) begin
            data_o <= alloc_data_i;
        end
    end

endmodule

// File: rtl/rob_mw_core.sv
// Multi-way reorder buffer: WAYS allocations and in-order commits per cycle, WBPORTS writebacks.
module rob_mw_core
    import rob_pkg::*;
#(
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned WAYS    = 2,
    parameter int unsigned WBPORTS = 2,
    localparam int unsigned IDXW   = $clog2(DEPTH),
    localparam int unsigned CNTW   = $clog2(DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic                    flush_i,
    input  logic [WAYS-1:0]         wren_i,
    input  logic [WAYS-1:0]         wcomplete_i,
    input  logic [WAYS*DWIDTH-1:0]  wdata_i,
    output logic [WAYS*IDXW-1:0]    wentrynum_o,
    output logic                    wready_o,
    input  logic [WBPORTS-1:0]      wb_valid_i,
    input  logic [WBPORTS*IDXW-1:0] wb_entry_i,
    input  logic [WBPORTS-1:0]      wb_exc_i,
    input  logic [WAYS-1:0]         rden_i,
    output logic [WAYS-1:0]         rvalid_o,
    output logic [WAYS-1:0]         rcomplete_o,
    output logic [WAYS-1:0]         rexc_o,
    output logic [WAYS*DWIDTH-1:0]  rdata_o,
    output logic [WAYS*IDXW-1:0]    rentrynum_o,
    output logic [CNTW-1:0]         count_o,
    output logic                    empty_o,
    output logic                    full_o
);

    localparam int unsigned LINMASK = (32'd2 << IDXW) - 32'd1;

    rob_ptr_t          wptr_q, rptr_q;
    logic [IDXW-1:0]   widx [WAYS];
    logic [IDXW-1:0]   ridx [WAYS];
    int unsigned       n_alloc, n_commit;

    logic [DEPTH-1:0]  ent_valid, ent_complete, ent_exc;
    logic [DWIDTH-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]  alloc_vec, alloc_cmp, commit_vec, wb_hit, wb_exc;
    logic [DWIDTH-1:0] alloc_data [DEPTH];

    // Occupancy and status derived from the pointer distance.
    always_comb begin
        int unsigned wl, rl, occ;
        wl       = ptr_lin(wptr_q, IDXW);
        rl       = ptr_lin(rptr_q, IDXW);
        occ      = (wl - rl) & LINMASK;
        count_o  = CNTW'(occ);
        empty_o  = (wl == rl);
        full_o   = ((wl ^ rl) == DEPTH);
        wready_o = (DEPTH - occ) >= WAYS;
    end

    // Slot-to-entry index mapping for the allocate and commit windows.
    always_comb begin
        for (int unsigned k = 0; k < WAYS; k++) begin
            widx[k] = IDXW'(ptr_lin(wptr_q, IDXW) + k);
            ridx[k] = IDXW'(ptr_lin(rptr_q, IDXW) + k);
            wentrynum_o[k*IDXW +: IDXW] = widx[k];
        end
    end

    // Head window read-out, combinational from entry state.
    always_comb begin
        rvalid_o    = '0;
        rcomplete_o = '0;
        rexc_o      = '0;
        rdata_o     = '0;
        rentrynum_o = '0;
        for (int unsigned k = 0; k < WAYS; k++) begin
            rvalid_o[k]                   = 32'(count_o) > k;
            rcomplete_o[k]                = ent_complete[ridx[k]];
            rexc_o[k]                     = ent_exc[ridx[k]];
            rdata_o[k*DWIDTH +: DWIDTH]   = ent_data[ridx[k]];
            rentrynum_o[k*IDXW +: IDXW]   = ridx[k];
        end
    end

    // Allocation: leading-ones prefix of wren_i, all-or-nothing on wready_o.
    always_comb begin
        logic run;
        n_alloc   = 0;
        run       = wready_o;
        alloc_vec = '0;
        alloc_cmp = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            alloc_data[e] = '0;
        end
        for (int unsigned k = 0; k < WAYS; k++) begin
            if (run && wren_i[k]) begin
                n_alloc                = n_alloc + 1;
                alloc_vec[widx[k]]     = 1'b1;
                alloc_cmp[widx[k]]     = wcomplete_i[k];
                alloc_data[widx[k]]    = wdata_i[k*DWIDTH +: DWIDTH];
            end else begin
                run = 1'b0;
            end
        end
    end

    // Commit: in-order prefix of ready slots, stopping after the first exception.
    always_comb begin
        logic run;
        n_commit   = 0;
        run        = 1'b1;
        commit_vec = '0;
        for (int unsigned k = 0; k < WAYS; k++) begin
            if (run && rden_i[k] && rvalid_o[k] && rcomplete_o[k]) begin
                n_commit            = n_commit + 1;
                commit_vec[ridx[k]] = 1'b1;
                if (rexc_o[k]) begin
                    run = 1'b0;
                end
            end else begin
                run = 1'b0;
            end
        end
    end

    // Writeback decode: hits from all ports on one entry are OR-ed together.
    always_comb begin
        wb_hit = '0;
        wb_exc = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            for (int unsigned p = 0; p < WBPORTS; p++) begin
                if (wb_valid_i[p] && (wb_entry_i[p*IDXW +: IDXW] == IDXW'(e))) begin
                    wb_hit[e] = 1'b1;
                    wb_exc[e] = wb_exc[e] | wb_exc_i[p];
                end
            end
        end
    end

    // Pointer registers; flush rewinds both to zero.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= ptr_add(wptr_q, n_alloc, IDXW);
            rptr_q <= ptr_add(rptr_q, n_commit, IDXW);
        end
    end

    // Entry storage array.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        rob_mw_entry #(
            .DWIDTH(DWIDTH)
        ) u_entry (
            .clk_i           (clk_i),
            .srst_i          (srst_i),
            .flush_i         (flush_i),
            .alloc_i         (alloc_vec[e]),
            .alloc_complete_i(alloc_cmp[e]),
            .alloc_data_i    (alloc_data[e]),
            .wb_hit_i        (wb_hit[e]),
            .wb_exc_i        (wb_exc[e]),
            .commit_i        (commit_vec[e]),
            .valid_o         (ent_valid[e]),
            .complete_o      (ent_complete[e]),
            .exc_o           (ent_exc[e]),
            .data_o          (ent_data[e])
        );
    end

endmodule
